dev_io_seq: RTL

DEV_IO_SEQ -- requirements
Module: dev_io_seq

---
 rtl/dev_io_pkg.sv | 18 +
 rtl/code_fifo.sv | 56 +++++
 rtl/dev_io_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dev_io_pkg.sv
// Shared code width and handshake state encodings for the dev_io_seq block.
package dev_io_pkg;

  localparam int unsigned CODE_W = 5;

  typedef enum logic [1:0] {
    IN_IDLE     = 2'd0,
    IN_PRESENT  = 2'd1,
    IN_WAIT_LOW = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE     = 2'd0,
    OUT_ACK      = 2'd1,
    OUT_WAIT_LOW = 2'd2
  } out_state_t;

endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO of CODE_W-bit codes with occupancy count and flush.
module code_fifo #(
  parameter  int unsigned DEPTH  = 16,
  parameter  int unsigned CODE_W = 5,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = AW + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              push,
  input  logic [CODE_W-1:0] push_data,
  input  logic              pop,
  output logic [CODE_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dev_io_seq.sv
// Host-to-core code sequencer: input FIFO feeding a val-pulse handshake,
// output FIFO filled by an ack-pulse handshake.
module dev_io_seq
  import dev_io_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_wr_en,
  input  logic [CODE_W-1:0] in_wr_data,
  output logic              in_full,
  output logic [CW-1:0]     in_count,
  input  logic              out_rd_en,
  output logic [CODE_W-1:0] out_rd_data,
  output logic              out_empty,
  output logic [CW-1:0]     out_count,
  input  logic              core_input_rdy,
  output logic              core_input_val,
  output logic [CODE_W-1:0] core_input_data,
  input  logic              core_output_rdy,
  input  logic [CODE_W-1:0] core_output_data,
  output logic              core_output_ack
);

  in_state_t         in_state;
  out_state_t        out_state;
  logic [CODE_W-1:0] in_head;
  logic              in_empty;
  logic              in_pop;
  logic              out_full;
  logic              out_push;

  assign in_pop   = (in_state == IN_IDLE) && core_input_rdy && !in_empty && !flush;
  assign out_push = (out_state == OUT_IDLE) && core_output_rdy && !out_full && !flush;

  code_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_in_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (in_wr_en),
    .push_data (in_wr_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  code_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) u_out_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .push      (out_push),
    .push_data (core_output_data),
    .pop       (out_rd_en),
    .head      (out_rd_data),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_state        <= IN_IDLE;
      core_input_val  <= 1'b0;
      core_input_data <= '0;
    end else if (flush) begin
      in_state       <= IN_IDLE;
      core_input_val <= 1'b0;
    end else begin
      unique case (in_state)
        IN_IDLE: begin
          if (in_pop) begin
            core_input_data <= in_head;
            core_input_val  <= 1'b1;
            in_state        <= IN_PRESENT;
          end
        end
        IN_PRESENT: begin
          core_input_val <= 1'b0;
          in_state       <= IN_WAIT_LOW;
        end
        IN_WAIT_LOW: begin
          if (!core_input_rdy) in_state <= IN_IDLE;
        end
        default: begin
          core_input_val <= 1'b0;
          in_state       <= IN_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_state       <= OUT_IDLE;
      core_output_ack <= 1'b0;
    end else if (flush) begin
      out_state       <= OUT_IDLE;
      core_output_ack <= 1'b0;
    end else begin
      unique case (out_state)
        OUT_IDLE: begin
          if (out_push) begin
            core_output_ack <= 1'b1;
            out_state       <= OUT_ACK;
          end
        end
        OUT_ACK: begin
          core_output_ack <= 1'b0;
          out_state       <= OUT_WAIT_LOW;
        end
        OUT_WAIT_LOW: begin
          if (!core_output_rdy) out_state <= OUT_IDLE;
        end
        default: begin
          core_output_ack <= 1'b0;
          out_state       <= OUT_IDLE;
        end
      endcase
    end
  end

endmodule
